// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: combinational decode into a DEPTH-entry result FIFO.
// Optional macro IMMGEN_ZICSR_EN enables the Zicsr ZIMM format on opcode 1110011.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_I     = 3'd0;
  localparam logic [2:0] FMT_S     = 3'd1;
  localparam logic [2:0] FMT_B     = 3'd2;
  localparam logic [2:0] FMT_U     = 3'd3;
  localparam logic [2:0] FMT_J     = 3'd4;
  localparam logic [2:0] FMT_SHAMT = 3'd5;
  localparam logic [2:0] FMT_ZIMM  = 3'd6;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Every immediate is first assembled as a signed 32-bit value, then widened.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b1;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_imm     = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      7'b0010011: begin
        dec_illegal = 1'b0;
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) dec_imm = XLEN'(in_instr[25:20]);
          else            dec_imm = XLEN'(in_instr[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      7'b0011011: begin
        // Word-sized ops exist only on RV64; shift amount is always 5 bits.
        if (XLEN == 64) begin
          dec_illegal = 1'b0;
          if (is_shift) begin
            dec_fmt = FMT_SHAMT;
            dec_imm = XLEN'(in_instr[24:20]);
          end else begin
            dec_fmt = FMT_I;
            dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:20]});
          end
        end
      end
      7'b0100011: begin
        dec_imm     = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      7'b1100011: begin
        dec_imm     = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0});
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm     = sext32({in_instr[31:12], 12'b0});
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      7'b1101111: begin
        dec_imm     = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0});
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
`ifdef IMMGEN_ZICSR_EN
      7'b1110011: begin
        dec_illegal = 1'b0;
        if (funct3[2]) begin
          dec_imm = XLEN'(in_instr[19:15]);
          dec_fmt = FMT_ZIMM;
        end
      end
`endif
      default: ;
    endcase
  end

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Payload storage needs no reset: reads are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign out_imm     = out_valid ? head.imm     : '0;
  assign out_fmt     = out_valid ? head.fmt     : 3'd0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;
  assign out_tag     = out_valid ? head.tag     : '0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances driven in lockstep.
module tb_imm_gen_pipe;

  logic        clk, reset, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_imm, out_tag;
  logic [2:0]  out_fmt;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  int n_cmp = 0;
  int n_err = 0;

  imm_gen_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(32)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag));

  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(32)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IMMGEN_ZICSR_EN
  localparam logic [63:0] Z_IMM = 64'd15;
  localparam logic [2:0]  Z_FMT = 3'd6;
  localparam logic        Z_ILL = 1'b0;
  localparam logic        Z13_ILL = 1'b0;
`else
  localparam logic [63:0] Z_IMM = 64'd0;
  localparam logic [2:0]  Z_FMT = 3'd7;
  localparam logic        Z_ILL = 1'b1;
  localparam logic        Z13_ILL = 1'b1;
`endif

  localparam int NV = 14;
  logic [31:0] v_instr [NV] = '{32'hFFC12083, 32'h00512423, 32'hFE000CE3, 32'h123450B7,
                                32'h001000EF, 32'h40315093, 32'h00000000, 32'h80008067,
                                32'hFFF1009B, 32'h0221109B, 32'h02211093, 32'h800000B7,
                                32'h0007D073, 32'h34011073};
  logic [31:0] v_imm32 [NV] = '{32'hFFFFFFFC, 32'h8, 32'hFFFFFFF8, 32'h12345000,
                                32'h800, 32'h3, 32'h0, 32'hFFFFF800,
                                32'h0, 32'h0, 32'h2, 32'h80000000, Z_IMM[31:0], 32'h0};
  logic [2:0]  v_fmt32 [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0,
                                3'd7, 3'd7, 3'd5, 3'd3, Z_FMT, 3'd7};
  logic        v_ill32 [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b0, Z_ILL, Z13_ILL};
  logic [63:0] v_imm64 [NV] = '{64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFFFFFFFFF8, 64'h12345000,
                                64'h800, 64'h3, 64'h0, 64'hFFFFFFFFFFFFF800,
                                64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h22, 64'hFFFFFFFF80000000,
                                Z_IMM, 64'h0};
  logic [2:0]  v_fmt64 [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0,
                                3'd0, 3'd5, 3'd5, 3'd3, Z_FMT, 3'd7};
  logic        v_ill64 [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, Z_ILL, Z13_ILL};

  task automatic push_one(input logic [31:0] instr, input logic [31:0] tag);
    in_valid = 1'b1; in_instr = instr; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({out_imm, out_fmt, out_illegal, out_tag} !== '0) begin
      n_err++; $display("FAIL rst_outputs: got imm=%h fmt=%0d ill=%b tag=%h want all 0", out_imm, out_fmt, out_illegal, out_tag);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_decode();
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = v_instr[i]; in_tag = 32'h1000 + 32'(i);
      if (i == 0) begin
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %b want 0", out_valid); end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dec_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_imm !== v_imm32[i]) begin n_err++; $display("FAIL dec_imm32[%0d]: got %h want %h", i, out_imm, v_imm32[i]); end
      n_cmp++; if (out_fmt !== v_fmt32[i]) begin n_err++; $display("FAIL dec_fmt32[%0d]: got %0d want %0d", i, out_fmt, v_fmt32[i]); end
      n_cmp++; if (out_illegal !== v_ill32[i]) begin n_err++; $display("FAIL dec_ill32[%0d]: got %b want %b", i, out_illegal, v_ill32[i]); end
      n_cmp++; if (out_tag !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL dec_tag[%0d]: got %h want %h", i, out_tag, 32'h1000 + 32'(i)); end
      n_cmp++; if (out_imm64 !== v_imm64[i]) begin n_err++; $display("FAIL dec_imm64[%0d]: got %h want %h", i, out_imm64, v_imm64[i]); end
      n_cmp++; if (out_fmt64 !== v_fmt64[i]) begin n_err++; $display("FAIL dec_fmt64[%0d]: got %0d want %0d", i, out_fmt64, v_fmt64[i]); end
      n_cmp++; if (out_illegal64 !== v_ill64[i]) begin n_err++; $display("FAIL dec_ill64[%0d]: got %b want %b", i, out_illegal64, v_ill64[i]); end
      pop_one();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dec_pop[%0d]: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_fifo_full();
    logic acc;
    out_ready = 1'b0; in_instr = 32'h123450B7;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_tag = 32'(k);
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'(k < 4)) begin n_err++; $display("FAIL fill_in_ready[%0d]: got %b want %b", k, in_ready, 1'(k < 4)); end
    end
    in_tag = 32'd5;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_hold_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_tag !== 32'd1) begin n_err++; $display("FAIL full_head_stable: got %h want 1", out_tag); end
    out_ready = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want 1", e, out_valid); end
      n_cmp++; if (out_tag !== 32'(e)) begin n_err++; $display("FAIL drain_tag[%0d]: got %h want %h", e, out_tag, 32'(e)); end
      if (e <= 2) begin
        n_cmp++; if (in_ready !== 1'(e == 2)) begin n_err++; $display("FAIL drain_in_ready[%0d]: got %b want %b", e, in_ready, 1'(e == 2)); end
      end
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    n_cmp++; if ({out_imm, out_fmt, out_tag} !== '0) begin
      n_err++; $display("FAIL empty_zero: got imm=%h fmt=%0d tag=%h want 0", out_imm, out_fmt, out_tag);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] u;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      u = 20'hABC00 + 20'(k);
      in_instr = {u, 5'd1, 7'b0110111}; in_tag = 32'h2000 + 32'(k);
      if (k > 0) begin
        u = 20'hABC00 + 20'(k - 1);
        n_cmp++; if (out_tag !== 32'h2000 + 32'(k - 1)) begin n_err++; $display("FAIL b2b_tag[%0d]: got %h want %h", k, out_tag, 32'h2000 + 32'(k - 1)); end
        n_cmp++; if (out_imm !== {u, 12'h000}) begin n_err++; $display("FAIL b2b_imm[%0d]: got %h want %h", k, out_imm, {u, 12'h000}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, in_ready); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_tag !== 32'h2003) begin n_err++; $display("FAIL b2b_last_tag: got %h want 2003", out_tag); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    push_one(32'hFFC12083, 32'hA1);
    push_one(32'h00512423, 32'hA2);
    n_cmp++; if (out_tag !== 32'hA1) begin n_err++; $display("FAIL mr_pre_head: got %h want a1", out_tag); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_async_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_async_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_no_stale: got %b want 0", out_valid); end
    push_one(32'h001000EF, 32'hB1);
    n_cmp++; if (out_tag !== 32'hB1) begin n_err++; $display("FAIL mr_new_head: got %h want b1", out_tag); end
    n_cmp++; if (out_imm !== 32'h800) begin n_err++; $display("FAIL mr_new_imm: got %h want 800", out_imm); end
    pop_one();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_final_empty: got %b want 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    test_reset();
    test_decode();
    test_fifo_full();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V core's decode path. It accepts instructions over a valid/ready handshake and decodes every RV32I/RV64I immediate format (I, S, B, U, J, plus shift-amount). Results are sign-extended to XLEN and buffered in a DEPTH-entry FIFO. Each result carries a format code, an illegal-opcode flag and a pass-through tag, so fetch and execute can be decoupled.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- DEPTH, 4, result FIFO entries; power of two, ≥2.
- TAG_W, 32, width of the sideband tag (typically the PC).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction offered.
- in_ready  output  1  block can accept this cycle.
- in_instr  input  32  instruction word.
- in_tag  input  TAG_W  sideband, returned unchanged.
- out_valid  output  1  result at FIFO head.
- out_ready  input  1  consumer takes head this cycle.
- out_imm  output  XLEN  extended immediate.
- out_fmt  output  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 ZIMM, 7 NONE.
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the head entry.

## Operation
- Decode is combinational on in_instr. The result is written to the FIFO on accept (in_valid & in_ready).
- Opcode to format mapping:
  - 0000011, 1100111 → I: sign-extend instr[31:20].
  - 0010011 → I, except funct3 001/101 → SHAMT.
  - 0011011 (XLEN=64 only) → I, except funct3 001/101 → SHAMT.
  - 0100011 → S: {instr[31:25], instr[11:7]}, sign-extended.
  - 1100011 → B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 0110111, 0010111 → U: {instr[31:12], 12'b0}, sign-extended to XLEN.
  - 1101111 → J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
- SHAMT zero-extends the shift amount:
  - instr[24:20] for XLEN=32 and for opcode 0011011.
  - instr[25:20] for opcode 0010011 at XLEN=64.
- Any other opcode (including 0011011 at XLEN=32): out_imm=0, out_fmt=7, out_illegal=1. The entry is still queued in order.
- FIFO behaviour:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - Pointers wrap modulo DEPTH.
  - Strict in-order delivery.
- Simultaneous push and pop: count is unchanged and both pointers advance. At full, in_ready=0, so no push occurs even if a pop happens that cycle.
- While out_valid=0: out_imm, out_fmt, out_illegal and out_tag are driven 0.
- Output stability: while out_valid=1 and out_ready=0, the head outputs hold stable.

## Timing
- Reset values:
  - count=0, pointers=0.
  - in_ready=1, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- Reset asserted mid-operation discards all queued entries immediately (asynchronously).
- Latency: an instruction accepted at edge N is presented on out_* after edge N, i.e. one cycle, with no bypass from an empty FIFO.
- Throughput: one instruction per cycle, sustained when out_ready=1.
- in_ready and out_valid depend only on registered count, with no combinational path from out_ready.

## Configuration
- IMMGEN_ZICSR_EN defined:
  - Opcode 1110011 with funct3[2]=1 → ZIMM: out_imm = zero-extended instr[19:15], out_fmt=6.
  - Opcode 1110011 with funct3[2]=0 → out_imm=0, out_fmt=7, out_illegal=0.
- IMMGEN_ZICSR_EN undefined: opcode 1110011 is treated as illegal (out_fmt=7, out_illegal=1).

## Test plan
- XLEN=32, push 0xFFC12083 (lw) → one cycle later out_imm=0xFFFFFFFC, fmt=0; then push 0x00512423 (sw) → out_imm=0x00000008, fmt=1.
- Push 0xFE000CE3 (beq −8) → 0xFFFFFFF8, fmt=2. Push 0x123450B7 (lui) → 0x12345000, fmt=3. Push 0x001000EF (jal +2048) → 0x00000800, fmt=4.
- Push 0x40315093 (srai x1,x2,3) → out_imm=3, fmt=5 (not 0x403). Push 0x00000000 → out_imm=0, fmt=7, out_illegal=1.
- DEPTH=4, out_ready=0, push tags 1..5 → in_ready falls after the 4th accept and the 5th is held. Then out_ready=1 → tags 1..5 delivered in order, one per cycle.
- FIFO holding 2 entries, reset pulsed mid-cycle → out_valid=0 and in_ready=1 immediately, and no stale entry appears after release.
- XLEN=64, push 0xFFC12083 → 0xFFFFFFFFFFFFFFFC. With IMMGEN_ZICSR_EN, push 0x0007D073 (csrrwi zimm=15) → out_imm=15, fmt=6.
